maze_map_ram: RTL

- Parametrised 2-D cell-map memory for the maze solver datapath.
- Holds one bit per cell (1 = wall/visited, 0 = free) in a 2^X_BITS by 2^Y_BITS grid.
- Serves single-cell reads and writes, plus a multi-cycle neighbour query returning the N/E/S/W cells of a position.
- Clears itself after reset with a row-sweep FSM, and talks to the controller FSM over a valid/ready request and valid-only response interface.

---
 rtl/maze_map_ram_if.sv | 42 ++++
 rtl/maze_map_ram.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/maze_map_ram_if.sv
// rtl/maze_map_ram_if.sv - request/response bundle between the maze controller and maze_map_ram
//
// Purpose: groups the valid/ready request channel, the valid-only response channel
//          and the busy flag of the cell-map memory.
// Signals:
//   req_valid  controller -> map  request present
//   req_ready  map -> controller  request can be accepted this cycle
//   req_op     controller -> map  00 READ, 01 WRITE, 10 NBR, 11 treated as READ
//   req_x      controller -> map  column of target cell
//   req_y      controller -> map  row of target cell
//   req_wdata  controller -> map  write data for WRITE
//   rsp_valid  map -> controller  one-cycle response pulse
//   rsp_data   map -> controller  cell value for READ, 0 otherwise
//   rsp_nbr    map -> controller  {N,E,S,W} for NBR, 0 otherwise
//   busy       map -> controller  high during the clear sweep or a neighbour query
// Modports: master (controller side), slave (map side).

interface maze_map_ram_if #(
    parameter int X_BITS = 4,
    parameter int Y_BITS = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [X_BITS-1:0] req_x;
    logic [Y_BITS-1:0] req_y;
    logic              req_wdata;
    logic              rsp_valid;
    logic              rsp_data;
    logic [3:0]        rsp_nbr;
    logic              busy;

    modport master (
        output req_valid, req_op, req_x, req_y, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_nbr, busy
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_nbr, busy
    );
endinterface

// File: rtl/maze_map_ram.sv
// rtl/maze_map_ram.sv - 2-D one-bit-per-cell maze map with single-cell and neighbour queries
//
// Purpose: 2^X_BITS x 2^Y_BITS bit map (1 = wall/visited). Clears itself row by row
//          after reset, then serves READ/WRITE at one per cycle and a 3-cycle
//          neighbour (N/E/S/W) query.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset (restarts the clear sweep)
//   bus  maze_map_ram_if.slave request/response bundle
// Configuration:
//   MAZE_BOUNDARY_WALL_EN  when defined, off-grid neighbours read as 1 (walls);
//                          otherwise they read as 0 (free).

module maze_map_ram #(
    parameter int   X_BITS    = 4,
    parameter int   Y_BITS    = 4,
    parameter logic CLEAR_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    maze_map_ram_if.slave bus
);
    localparam int MAP_W = 1 << X_BITS;
    localparam int MAP_H = 1 << Y_BITS;

`ifdef MAZE_BOUNDARY_WALL_EN
    localparam logic BOUND_VAL = 1'b1;
`else
    localparam logic BOUND_VAL = 1'b0;
`endif

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_NBR   = 2'b10;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_NBR_ROW,
        ST_NBR_N,
        ST_NBR_S
    } state_t;

    state_t            state_q, state_d;
    logic [Y_BITS-1:0] clr_q, clr_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic              n_q, n_d;
    logic              e_q, e_d;
    logic              w_q, w_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_data_q, rsp_data_d;
    logic [3:0]        rsp_nbr_q, rsp_nbr_d;

    logic [MAP_W-1:0]  map_q [MAP_H];

    logic              clr_we;
    logic              cell_we;
    logic              accept;

    // Neighbour addresses; the wrapped values are never used at an edge because
    // the boundary comparisons below substitute BOUND_VAL there.
    logic [X_BITS-1:0] x_e, x_w;
    logic [Y_BITS-1:0] y_n, y_s;
    logic              e_bit, w_bit, n_bit, s_bit;

    assign x_e = x_q + X_BITS'(1);
    assign x_w = x_q - X_BITS'(1);
    assign y_n = y_q - Y_BITS'(1);
    assign y_s = y_q + Y_BITS'(1);

    assign e_bit = (x_q == {X_BITS{1'b1}}) ? BOUND_VAL : map_q[y_q][x_e];
    assign w_bit = (x_q == '0)             ? BOUND_VAL : map_q[y_q][x_w];
    assign n_bit = (y_q == '0)             ? BOUND_VAL : map_q[y_n][x_q];
    assign s_bit = (y_q == {Y_BITS{1'b1}}) ? BOUND_VAL : map_q[y_s][x_q];

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        e_d         = e_q;
        w_d         = w_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_nbr_d   = rsp_nbr_q;
        clr_we      = 1'b0;
        cell_we     = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                clr_d  = clr_q + Y_BITS'(1);
                if (clr_q == {Y_BITS{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        OP_WRITE: begin
                            cell_we     = 1'b1;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = 1'b0;
                            rsp_nbr_d   = 4'b0000;
                        end
                        OP_NBR: begin
                            x_d     = bus.req_x;
                            y_d     = bus.req_y;
                            state_d = ST_NBR_ROW;
                        end
                        default: begin
                            // READ and the reserved op: registered single-cell read.
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = map_q[bus.req_y][bus.req_x];
                            rsp_nbr_d   = 4'b0000;
                        end
                    endcase
                end
            end
            ST_NBR_ROW: begin
                e_d     = e_bit;
                w_d     = w_bit;
                state_d = ST_NBR_N;
            end
            ST_NBR_N: begin
                n_d     = n_bit;
                state_d = ST_NBR_S;
            end
            ST_NBR_S: begin
                // South is taken straight from the map so the response leaves
                // on the same edge that returns the FSM to IDLE.
                rsp_valid_d = 1'b1;
                rsp_data_d  = 1'b0;
                rsp_nbr_d   = {n_q, e_q, s_bit, w_q};
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= 1'b0;
            e_q         <= 1'b0;
            w_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            rsp_nbr_q   <= 4'b0000;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            e_q         <= e_d;
            w_q         <= w_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nbr_q   <= rsp_nbr_d;
        end
    end

    // Map contents are not reset directly; the clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            map_q[clr_q] <= {MAP_W{CLEAR_VAL}};
        end else if (cell_we) begin
            map_q[bus.req_y][bus.req_x] <= bus.req_wdata;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_nbr   = rsp_nbr_q;

endmodule
